mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/mem_responder_byte_merge.sv | 18 +
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the memory responder and its byte-lane merge.
package mem_resp_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/mem_responder_byte_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new byte, others keep the old one.
module byte_merge
  import mem_resp_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-wide memory responder with byte-enable stores, programmable wait states and
// valid/ready request/response handshakes.
//
//   state  | meaning
//   IDLE   | ready for a request; latches it on req_valid
//   WAIT   | counting down WAIT_CYCLES wait states
//   COMMIT | single-cycle array access, response data registered
//   RESP   | response held until rsp_ready
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [29:0]       widx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] old_word;
  logic [WORD_W-1:0] merged;
  logic              unused_addr_bits;

  // Byte offset within the word never affects indexing.
  assign unused_addr_bits = ^req_addr[1:0];

  assign accept   = (state_q == IDLE) && req_valid;
  assign in_range = widx_q < 30'(DEPTH_WORDS);
  assign idx      = widx_q[IDX_W-1:0];
  assign old_word = mem_q[idx];

  byte_merge u_merge (
    .old_word (old_word),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (WAIT_CYCLES > 0) ? WAIT : COMMIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        widx_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt_q   <= CNT_W'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (state_q == COMMIT) begin
        if (!in_range) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          rsp_rdata <= wr_q ? merged : old_word;
          rsp_err   <= 1'b0;
        end
      end else if (state_q == RESP && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

  // The store is cleared by reset, so committed data does not survive it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (state_q == COMMIT && in_range && wr_q) begin
      mem_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int DEPTH = 64;
  localparam int W     = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];
  int          lat_q [$];
  logic [31:0] last_rdata = '0;
  bit          prev_valid = 1'b0;
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [32:0] model_access(input bit wr, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    int unsigned idx;
    idx = addr >> 2;
    if (idx >= DEPTH) return {1'b1, 32'h0};
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    return {1'b0, model[idx]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Called at posedge+1; holds the request until accepted, then scrambles the bus.
  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    int t = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!req_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) begin
      fail("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_access(wr, addr, wdata, be));
    lat_q.push_back(cycle + 1 + W + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (lat_q.size() == 0) fail("unexpected_rsp_valid");
        else check("rsp_latency_cycle", cycle, lat_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_response");
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[31:0]);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
          last_rdata = rsp_rdata;
        end
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;

    send(1'b0, 32'h10, 32'h0, 4'h0);
    send(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    drain();
    check("read_after_write", last_rdata, 32'hDEADBEEF);

    send(1'b1, 32'h24, 32'h11223344, 4'hF);
    send(1'b1, 32'h24, 32'h000000AA, 4'h1);
    drain();
    check("partial_be0001", last_rdata, 32'h112233AA);
    send(1'b1, 32'h24, 32'hBBBB0000, 4'hC);
    drain();
    check("partial_be1100", last_rdata, 32'hBBBB33AA);
    send(1'b1, 32'h26, 32'hFFFFFFFF, 4'h0);
    drain();
    check("write_be0000_noop", last_rdata, 32'hBBBB33AA);

    send(1'b0, 32'h100, 32'h0, 4'h0);
    drain();
    check("oob_rdata_zero", last_rdata, 32'h0);
    send(1'b0, 32'hFC, 32'h0, 4'h0);
    drain();

    // Backpressure: response must hold and no new request may be taken.
    rsp_ready = 1'b0;
    send(1'b0, 32'h20, 32'h0, 4'h0);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!rsp_valid) fail("bp_rsp_valid_timeout");
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_req_ready", {31'b0, req_ready}, 32'd1);
    check("bp_release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_release_rdata_hold", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset while the write sits in WAIT: it must never land, and the store is wiped.
    send(1'b1, 32'h08, 32'h00000055, 4'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    clear_model();
    @(negedge clk);
    check("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    check("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midreset_rsp_rdata", rsp_rdata, 32'h0);
    check("midreset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 32'h08, 32'h0, 4'h0);
    drain();
    check("midreset_read_08", last_rdata, 32'h0);
    send(1'b0, 32'h20, 32'h0, 4'h0);
    drain();
    check("store_cleared_20", last_rdata, 32'h0);

    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1, 2, 3: a = $urandom_range(0, 63);
        default: a = $urandom_range(0, 255);
      endcase
      send(1'($urandom), a, $urandom, 4'($urandom));
    end
    drain();
    rand_bp = 1'b0;
    rsp_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
